// File: rtl/frame_bank_scheduler.sv
// -----------------------------------------------------------------------------
// frame_bank_scheduler
//
// Ping-pong frame buffer scheduler. Capture writes one RAM bank while this
// block streams the other bank out to a UART, one byte at a time, bracketed by
// a guard gap before and after each frame. A frame-done pulse that arrives
// while a frame is still being sent is dropped and counted (saturating).
//
// Parameters
//   BYTES_PER_FRAME  bytes streamed per frame
//   ADDR_W           RAM read-address width
//   GAP_CYCLES       guard-gap length in Clk cycles (before and after a frame)
//   CNT_W            gap-counter width
//
// Ports
//   Clk               system clock, rising edge
//   i_Rst_n           synchronous active-low reset
//   i_Frame_Done      one-cycle pulse: write bank holds a complete frame
//   i_Rd_Data         RAM read data, valid one cycle after o_Rd_En
//   i_Tx_Busy         UART transmitter busy
//   o_Wr_Bank         bank selected for capture writes
//   o_Rd_Bank         bank selected for reads (always ~o_Wr_Bank)
//   o_Rd_Addr         RAM read address
//   o_Rd_En           RAM read strobe
//   o_Tx_Data         byte handed to the UART
//   o_Tx_Start        one-cycle UART start pulse
//   o_Frame_Indicator high only while idle
//   o_Busy            high whenever not idle
//   o_Drop_Count      number of dropped frames, saturating at 255
// -----------------------------------------------------------------------------
module frame_bank_scheduler #(
  parameter int BYTES_PER_FRAME = 9216,
  parameter int ADDR_W          = 14,
  parameter int GAP_CYCLES      = 62500000,
  parameter int CNT_W           = 26
) (
  input  logic              Clk,
  input  logic              i_Rst_n,
  input  logic              i_Frame_Done,
  input  logic [7:0]        i_Rd_Data,
  input  logic              i_Tx_Busy,
  output logic              o_Wr_Bank,
  output logic              o_Rd_Bank,
  output logic [ADDR_W-1:0] o_Rd_Addr,
  output logic              o_Rd_En,
  output logic [7:0]        o_Tx_Data,
  output logic              o_Tx_Start,
  output logic              o_Frame_Indicator,
  output logic              o_Busy,
  output logic [7:0]        o_Drop_Count
);

  typedef enum logic [2:0] {
    IDLE,
    PRE_GAP,
    RD,
    RD_WAIT,
    WAIT_ACK,
    WAIT_DONE,
    POST_GAP
  } state_t;

  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(BYTES_PER_FRAME - 1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    gap_cnt, gap_cnt_nxt;
  logic                wr_bank_nxt;
  logic [ADDR_W-1:0]   rd_addr_nxt;
  logic [7:0]          tx_data_nxt;
  logic                tx_start_nxt;
  logic [7:0]          drop_nxt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // The read strobe fires in the very cycle the transmitter is seen idle while
  // in RD, so a busy UART stalls the read without losing a cycle once it frees.
  assign o_Rd_En = (state == RD) && !i_Tx_Busy;

  always_comb begin
    state_nxt    = state;
    gap_cnt_nxt  = gap_cnt;
    wr_bank_nxt  = o_Wr_Bank;
    rd_addr_nxt  = o_Rd_Addr;
    tx_data_nxt  = o_Tx_Data;
    tx_start_nxt = 1'b0;
    drop_nxt     = o_Drop_Count;

    // Any frame-done outside IDLE (including the last POST_GAP cycle) is a drop.
    if (i_Frame_Done && (state != IDLE)) begin
      drop_nxt = sat_inc(o_Drop_Count);
    end

    case (state)
      IDLE: begin
        if (i_Frame_Done) begin
          wr_bank_nxt = ~o_Wr_Bank;
          gap_cnt_nxt = '0;
          state_nxt   = PRE_GAP;
        end
      end
      PRE_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          rd_addr_nxt = '0;
          state_nxt   = RD;
        end else begin
          gap_cnt_nxt = gap_cnt + 1'b1;
        end
      end
      RD: begin
        if (!i_Tx_Busy) begin
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // RAM data for the strobe issued last cycle is on i_Rd_Data now.
        tx_data_nxt  = i_Rd_Data;
        tx_start_nxt = 1'b1;
        state_nxt    = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (i_Tx_Busy) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!i_Tx_Busy) begin
          if (o_Rd_Addr < ADDR_LAST) begin
            rd_addr_nxt = o_Rd_Addr + 1'b1;
            state_nxt   = RD;
          end else begin
            rd_addr_nxt = '0;
            gap_cnt_nxt = '0;
            state_nxt   = POST_GAP;
          end
        end
      end
      POST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Register stage: state, counters and every output except the read strobe.
  always_ff @(posedge Clk) begin
    if (!i_Rst_n) begin
      state             <= IDLE;
      gap_cnt           <= '0;
      o_Wr_Bank         <= 1'b0;
      o_Rd_Bank         <= 1'b1;
      o_Rd_Addr         <= '0;
      o_Tx_Data         <= 8'h00;
      o_Tx_Start        <= 1'b0;
      o_Frame_Indicator <= 1'b1;
      o_Busy            <= 1'b0;
      o_Drop_Count      <= 8'h00;
    end else begin
      state             <= state_nxt;
      gap_cnt           <= gap_cnt_nxt;
      o_Wr_Bank         <= wr_bank_nxt;
      o_Rd_Bank         <= ~wr_bank_nxt;
      o_Rd_Addr         <= rd_addr_nxt;
      o_Tx_Data         <= tx_data_nxt;
      o_Tx_Start        <= tx_start_nxt;
      o_Frame_Indicator <= (state_nxt == IDLE);
      o_Busy            <= (state_nxt != IDLE);
      o_Drop_Count      <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_bank_scheduler
//
// Directed bench for frame_bank_scheduler with BYTES_PER_FRAME=4, GAP_CYCLES=3.
// A one-cycle-latency RAM model and a UART model (busy one cycle after start,
// for five cycles) surround the DUT. Each frame pushes its expected read
// strobes and transmitted bytes, with the cycle they must appear on, into
// queues; a negedge monitor pops and compares whenever the DUT strobes.
// -----------------------------------------------------------------------------
module tb_frame_bank_scheduler;

  logic        Clk = 1'b0;
  logic        i_Rst_n;
  logic        i_Frame_Done;
  logic [7:0]  i_Rd_Data;
  logic        i_Tx_Busy;
  logic        o_Wr_Bank;
  logic        o_Rd_Bank;
  logic [13:0] o_Rd_Addr;
  logic        o_Rd_En;
  logic [7:0]  o_Tx_Data;
  logic        o_Tx_Start;
  logic        o_Frame_Indicator;
  logic        o_Busy;
  logic [7:0]  o_Drop_Count;

  frame_bank_scheduler #(
    .BYTES_PER_FRAME(4),
    .ADDR_W(14),
    .GAP_CYCLES(3),
    .CNT_W(26)
  ) dut (
    .Clk(Clk),
    .i_Rst_n(i_Rst_n),
    .i_Frame_Done(i_Frame_Done),
    .i_Rd_Data(i_Rd_Data),
    .i_Tx_Busy(i_Tx_Busy),
    .o_Wr_Bank(o_Wr_Bank),
    .o_Rd_Bank(o_Rd_Bank),
    .o_Rd_Addr(o_Rd_Addr),
    .o_Rd_En(o_Rd_En),
    .o_Tx_Data(o_Tx_Data),
    .o_Tx_Start(o_Tx_Start),
    .o_Frame_Indicator(o_Frame_Indicator),
    .o_Busy(o_Busy),
    .o_Drop_Count(o_Drop_Count)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // RAM model: bank 0 and bank 1 preloaded, one-cycle read latency.
  logic [7:0] mem [0:1][0:3] = '{'{8'h11, 8'h22, 8'h33, 8'h44},
                                 '{8'hA1, 8'hB2, 8'hC3, 8'hD4}};
  logic [7:0] rd_data = 8'h00;
  always @(posedge Clk) if (o_Rd_En) rd_data <= mem[o_Rd_Bank][o_Rd_Addr[1:0]];
  assign i_Rd_Data = rd_data;

  // UART model: busy for 5 cycles starting 1 cycle after the start pulse.
  int   busy_cnt = 0;
  logic busy_force = 1'b0;
  always @(posedge Clk) begin
    if (o_Tx_Start) busy_cnt <= 5;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign i_Tx_Busy = (busy_cnt != 0) || busy_force;

  // Scoreboard
  typedef struct {
    int val;
    int cyc;
  } ev_t;
  ev_t rd_q[$];
  ev_t tx_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge Clk) begin
    if (o_Rd_En === 1'b1) begin
      if (rd_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_unexpected: strobe with addr 0x%0h at cycle %0d, none expected", o_Rd_Addr, cyc);
      end else begin
        ev_t e;
        e = rd_q.pop_front();
        check("rd_addr", 32'(o_Rd_Addr), 32'(e.val));
        check("rd_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (o_Tx_Start === 1'b1) begin
      if (tx_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL tx_unexpected: start with data 0x%0h at cycle %0d, none expected", o_Tx_Data, cyc);
      end else begin
        ev_t e;
        e = tx_q.pop_front();
        check("tx_data", 32'(o_Tx_Data), 32'(e.val));
        check("tx_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) tick();
  endtask

  // Full frame whose first read strobe lands on cycle r; following strobes come
  // every 9 cycles (2 to start, 1 to see busy, 5 busy, 1 back to RD).
  task automatic push_frame(input int r, input int bank);
    for (int k = 0; k < 4; k++) begin
      rd_q.push_back('{k, r + 9 * k});
      tx_q.push_back('{int'(mem[bank][k]), r + 2 + 9 * k});
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_wr_bank"}, 32'(o_Wr_Bank), 32'd0);
    check({tag, "_rd_bank"}, 32'(o_Rd_Bank), 32'd1);
    check({tag, "_rd_addr"}, 32'(o_Rd_Addr), 32'd0);
    check({tag, "_rd_en"}, 32'(o_Rd_En), 32'd0);
    check({tag, "_tx_data"}, 32'(o_Tx_Data), 32'd0);
    check({tag, "_tx_start"}, 32'(o_Tx_Start), 32'd0);
    check({tag, "_frame_ind"}, 32'(o_Frame_Indicator), 32'd1);
    check({tag, "_busy"}, 32'(o_Busy), 32'd0);
    check({tag, "_drop"}, 32'(o_Drop_Count), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    i_Rst_n      = 1'b0;
    i_Frame_Done = 1'b0;
    tick();
    tick();
    check_reset("rst");
    i_Rst_n = 1'b1;
    tick();

    // Frame 1: bank toggles to 1, read bank 0; first strobe at t+4.
    t = cyc;
    i_Frame_Done = 1'b1;
    push_frame(t + 4, 0);
    tick();
    i_Frame_Done = 1'b0;
    check("f1_wr_bank", 32'(o_Wr_Bank), 32'd1);
    check("f1_rd_bank", 32'(o_Rd_Bank), 32'd0);
    check("f1_busy", 32'(o_Busy), 32'd1);
    check("f1_frame_ind", 32'(o_Frame_Indicator), 32'd0);
    go_to(t + 42);
    check("f1_postgap_ind", 32'(o_Frame_Indicator), 32'd0);
    check("f1_postgap_busy", 32'(o_Busy), 32'd1);
    tick();
    check("f1_idle_ind", 32'(o_Frame_Indicator), 32'd1);
    check("f1_idle_busy", 32'(o_Busy), 32'd0);
    check("f1_idle_addr", 32'(o_Rd_Addr), 32'd0);

    // Frame 2: read bank 1 (A1..D4); drops mid-send and on last POST_GAP cycle.
    tick();
    t = cyc;
    i_Frame_Done = 1'b1;
    push_frame(t + 4, 1);
    tick();
    i_Frame_Done = 1'b0;
    check("f2_wr_bank", 32'(o_Wr_Bank), 32'd0);
    check("f2_rd_bank", 32'(o_Rd_Bank), 32'd1);
    go_to(t + 15);
    i_Frame_Done = 1'b1;
    tick();
    i_Frame_Done = 1'b0;
    check("f2_drop_mid", 32'(o_Drop_Count), 32'd1);
    check("f2_wr_bank_mid", 32'(o_Wr_Bank), 32'd0);
    go_to(t + 42);
    i_Frame_Done = 1'b1;
    tick();
    i_Frame_Done = 1'b0;
    check("f2_drop_last", 32'(o_Drop_Count), 32'd2);
    check("f2_wr_bank_end", 32'(o_Wr_Bank), 32'd0);
    check("f2_idle_ind", 32'(o_Frame_Indicator), 32'd1);
    check("f2_idle_busy", 32'(o_Busy), 32'd0);

    // Frame 3: transmitter held busy through RD entry; strobe when it falls.
    tick();
    t = cyc;
    i_Frame_Done = 1'b1;
    push_frame(t + 14, 0);
    tick();
    i_Frame_Done = 1'b0;
    busy_force = 1'b1;
    go_to(t + 13);
    check("f3_stall_rd_en", 32'(o_Rd_En), 32'd0);
    check("f3_stall_busy", 32'(o_Busy), 32'd1);
    tick();
    busy_force = 1'b0;
    go_to(t + 53);
    check("f3_idle_ind", 32'(o_Frame_Indicator), 32'd1);
    check("f3_wr_bank", 32'(o_Wr_Bank), 32'd1);

    // Frame 4: reset (together with a frame-done) in WAIT_DONE of byte 2.
    tick();
    t = cyc;
    i_Frame_Done = 1'b1;
    rd_q.push_back('{0, t + 4});
    tx_q.push_back('{int'(mem[1][0]), t + 6});
    rd_q.push_back('{1, t + 13});
    tx_q.push_back('{int'(mem[1][1]), t + 15});
    tick();
    i_Frame_Done = 1'b0;
    check("f4_wr_bank", 32'(o_Wr_Bank), 32'd0);
    go_to(t + 18);
    check("f4_pre_rst_addr", 32'(o_Rd_Addr), 32'd1);
    check("f4_pre_rst_tx_data", 32'(o_Tx_Data), 32'hB2);
    i_Rst_n      = 1'b0;
    i_Frame_Done = 1'b1;
    tick();
    i_Rst_n      = 1'b1;
    i_Frame_Done = 1'b0;
    check_reset("midrst");

    // Frame 5: restart after reset begins again at address 0 (bank 0).
    go_to(t + 25);
    t = cyc;
    i_Frame_Done = 1'b1;
    push_frame(t + 4, 0);
    tick();
    i_Frame_Done = 1'b0;
    check("f5_wr_bank", 32'(o_Wr_Bank), 32'd1);
    go_to(t + 43);
    check("f5_idle_ind", 32'(o_Frame_Indicator), 32'd1);

    // Saturation: stall in RD and pulse frame-done for 300 cycles.
    tick();
    t = cyc;
    i_Frame_Done = 1'b1;
    tick();
    busy_force = 1'b1;
    for (int i = 0; i < 254; i++) tick();
    check("sat_254", 32'(o_Drop_Count), 32'd254);
    tick();
    check("sat_255", 32'(o_Drop_Count), 32'd255);
    for (int i = 0; i < 45; i++) tick();
    i_Frame_Done = 1'b0;
    check("sat_300", 32'(o_Drop_Count), 32'd255);
    check("sat_wr_bank", 32'(o_Wr_Bank), 32'd0);
    check("sat_rd_en", 32'(o_Rd_En), 32'd0);
    i_Rst_n = 1'b0;
    tick();
    i_Rst_n    = 1'b1;
    busy_force = 1'b0;
    check("sat_rst_drop", 32'(o_Drop_Count), 32'd0);
    tick();
    tick();

    check("rd_queue_empty", 32'(rd_q.size()), 32'd0);
    check("tx_queue_empty", 32'(tx_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_bank_scheduler.md
FRAME_BANK_SCHEDULER -- requirements
Module: frame_bank_scheduler

Interface
REQ-001 SHALL have parameter BYTES_PER_FRAME, default 9216: bytes transmitted per frame.
REQ-002 SHALL have parameter ADDR_W, default 14: read-address width.
REQ-003 SHALL have parameter GAP_CYCLES, default 62500000: guard-gap length in Clk cycles, applied before and after each frame.
REQ-004 SHALL have parameter CNT_W, default 26: gap-counter width.
REQ-005 SHALL have port Clk  in  1  system clock; all logic on rising edge.
REQ-006 SHALL have port i_Rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port i_Frame_Done  in  1  one-cycle pulse from capture: write bank holds a complete frame.
REQ-008 SHALL have port i_Rd_Data  in  8  RAM read data, valid 1 cycle after o_Rd_En.
REQ-009 SHALL have port i_Tx_Busy  in  1  UART transmitter busy.
REQ-010 SHALL have port o_Wr_Bank  out  1  bank selected for capture writes.
REQ-011 SHALL have port o_Rd_Bank  out  1  bank selected for reads; always ~o_Wr_Bank.
REQ-012 SHALL have port o_Rd_Addr  out  ADDR_W  RAM read address.
REQ-013 SHALL have port o_Rd_En  out  1  RAM read strobe.
REQ-014 SHALL have port o_Tx_Data  out  8  byte to UART.
REQ-015 SHALL have port o_Tx_Start  out  1  one-cycle UART start pulse.
REQ-016 SHALL have port o_Frame_Indicator  out  1  high only in IDLE.
REQ-017 SHALL have port o_Busy  out  1  high in every state except IDLE.
REQ-018 SHALL have port o_Drop_Count  out  8  frames dropped, saturating.

Function
REQ-019 SHALL implement states IDLE, PRE_GAP, RD, RD_WAIT, WAIT_ACK, WAIT_DONE, POST_GAP; all outputs registered.
REQ-020 SHALL, in IDLE with i_Frame_Done=1 at cycle t, toggle o_Wr_Bank, clear the gap counter and enter PRE_GAP, all visible at t+1.
REQ-021 SHALL, on i_Frame_Done=1 in any non-IDLE state, leave the banks unchanged and increment o_Drop_Count, holding at 255.
REQ-022 SHALL remain in PRE_GAP exactly GAP_CYCLES cycles, then enter RD with o_Rd_Addr=0.
REQ-023 SHALL, in RD, hold until i_Tx_Busy=0; on that cycle drive o_Rd_En=1 for one cycle and enter RD_WAIT.
REQ-024 SHALL, in RD_WAIT, latch i_Rd_Data into o_Tx_Data, pulse o_Tx_Start for exactly one cycle (visible 2 cycles after the o_Rd_En cycle) and enter WAIT_ACK.
REQ-025 SHALL hold o_Tx_Data stable from o_Tx_Start until leaving WAIT_DONE.
REQ-026 SHALL leave WAIT_ACK when i_Tx_Busy=1 and leave WAIT_DONE when i_Tx_Busy=0.
REQ-027 SHALL, on leaving WAIT_DONE, enter RD with o_Rd_Addr+1 if o_Rd_Addr<BYTES_PER_FRAME-1; otherwise clear o_Rd_Addr to 0 and enter POST_GAP.
REQ-028 SHALL remain in POST_GAP exactly GAP_CYCLES cycles, then enter IDLE.
REQ-029 SHALL count i_Frame_Done on the final POST_GAP cycle as a drop, since the state is not IDLE.
REQ-030 SHALL never change o_Wr_Bank outside the IDLE-to-PRE_GAP transition.
REQ-031 SHALL keep o_Rd_En and o_Tx_Start low in IDLE, PRE_GAP and POST_GAP.

Reset
REQ-032 SHALL, on i_Rst_n=0 at a rising Clk edge, in any state including mid-frame, set: state IDLE, o_Wr_Bank=0, o_Rd_Bank=1, o_Rd_Addr=0, o_Rd_En=0, o_Tx_Data=0, o_Tx_Start=0, o_Frame_Indicator=1, o_Busy=0, o_Drop_Count=0, gap counter=0.
REQ-033 SHALL have reset take priority over i_Frame_Done on the same cycle.

Verification
Directed scenarios use BYTES_PER_FRAME=4, GAP_CYCLES=3, RAM model with 1-cycle latency, and a Tx model asserting busy 1 cycle after start for 5 cycles.
REQ-034 SHALL cover: reset, then i_Frame_Done pulse at t -> o_Wr_Bank=1 and o_Busy=1 at t+1; first o_Rd_En at t+4 with o_Rd_Addr=0.
REQ-035 SHALL cover: bank 1 preloaded with 0xA1,0xB2,0xC3,0xD4 -> exactly 4 o_Tx_Start pulses carrying those bytes in order; then POST_GAP of 3 cycles; then o_Frame_Indicator=1.
REQ-036 SHALL cover: i_Frame_Done pulsed mid-SEND and again on the last POST_GAP cycle -> o_Drop_Count=2 and o_Wr_Bank unchanged.
REQ-037 SHALL cover: i_Tx_Busy held high on RD entry for 10 cycles -> no o_Rd_En until busy falls; then o_Rd_En on that same cycle.
REQ-038 SHALL cover: i_Rst_n=0 during WAIT_DONE of byte 2 -> all outputs at reset values next cycle; a new frame restarts at address 0.
REQ-039 SHALL cover: 300 drop events -> o_Drop_Count saturates at 255.
